// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, ALU/mux encodings, FSM states and control vector shared by the MIPS multi-cycle control
package mc_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;
endpackage

// File: rtl/mc_main_control_if.sv
// mc_main_control_if: opcode/handshake inputs and datapath control outputs of the main control FSM
interface mc_main_control_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_op;
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, instr_count, illegal_op
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, instr_count, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state -> datapath control vector; only FETCH's IR/PC loads depend on mem_ready
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM with retired-instruction counter and sticky illegal-opcode flag
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  mc_main_control_if.master bus
);
  state_t           state, state_nxt;
  ctrl_t            ctrl;
  logic             retire, bad_op, illegal;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    state_nxt = FETCH;
    retire    = 1'b0;
    bad_op    = 1'b0;
    case (state)
      IDLE:   state_nxt = FETCH;
      FETCH:  state_nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE:
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXEC;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default:      bad_op = 1'b1;
        endcase
      MEMADR: state_nxt = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_nxt = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR: begin
        state_nxt = bus.mem_ready ? FETCH : MEMWR;
        retire    = bus.mem_ready;
      end
      EXEC:   state_nxt = ALUWB;
      ADDIEX: state_nxt = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retire = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt + CNT_W'(retire);
      illegal <= illegal | bad_op;
    end
  end
  mc_ctrl_decode u_decode (.state(state), .mem_ready(bus.mem_ready), .ctrl(ctrl));
  assign {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
          bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
          bus.alu_src_b, bus.alu_op, bus.pc_src} = ctrl;
  assign bus.instr_count = cnt;
  assign bus.illegal_op  = illegal;
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: random instruction stream against an instruction-level phase model; a 4-bit-counter twin checks wrap
module tb_mc_main_control;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errs = 0;
  int   checks = 0;
  logic [31:0] exp_cnt = '0;
  logic        exp_ill = 1'b0;
  mc_main_control_if #(.CNT_W(32)) bus ();
  mc_main_control_if #(.CNT_W(4))  bus4 ();
  assign bus4.opcode    = bus.opcode;
  assign bus4.mem_ready = bus.mem_ready;
  mc_main_control #(.CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mc_main_control #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  always #5 clk = ~clk;
  // vector bits: pw pwc iord mr mw irw m2r rd rw sa | src_b | alu_op | pc_src
  localparam logic [15:0] V_IDLE  = 16'b0000000000_00_00_00;
  localparam logic [15:0] V_FW    = 16'b0001000000_01_00_00;
  localparam logic [15:0] V_FG    = 16'b1001010000_01_00_00;
  localparam logic [15:0] V_DEC   = 16'b0000000000_11_00_00;
  localparam logic [15:0] V_ADR   = 16'b0000000001_10_00_00;
  localparam logic [15:0] V_RD    = 16'b0011000000_00_00_00;
  localparam logic [15:0] V_MWB   = 16'b0000001010_00_00_00;
  localparam logic [15:0] V_WR    = 16'b0010100000_00_00_00;
  localparam logic [15:0] V_EXEC  = 16'b0000000001_00_10_00;
  localparam logic [15:0] V_AWB   = 16'b0000000110_00_00_00;
  localparam logic [15:0] V_BR    = 16'b0100000001_00_01_01;
  localparam logic [15:0] V_IWB   = 16'b0000000010_00_00_00;
  localparam logic [15:0] V_JMP   = 16'b1000000000_00_00_10;
  function automatic logic [15:0] obs();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_src};
  endfunction
  function automatic logic [15:0] obs4();
    return {bus4.pc_write, bus4.pc_write_cond, bus4.iord, bus4.mem_read, bus4.mem_write,
            bus4.ir_write, bus4.mem_to_reg, bus4.reg_dst, bus4.reg_write, bus4.alu_src_a,
            bus4.alu_src_b, bus4.alu_op, bus4.pc_src};
  endfunction
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic [15:0] ev, input string tag);
    bus.mem_ready = r;
    @(negedge clk);
    check({tag, " ctl"}, 32'(obs()), 32'(ev));
    check({tag, " ctl4"}, 32'(obs4()), 32'(ev));
    check({tag, " count"}, bus.instr_count, exp_cnt);
    check({tag, " count4"}, 32'(bus4.instr_count), 32'(exp_cnt[3:0]));
    check({tag, " illegal"}, 32'(bus.illegal_op), 32'(exp_ill));
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bus.opcode = op;
    repeat (fw) step(1'b0, V_FW, "fetch_wait");
    step(1'b1, V_FG, "fetch");
    step(rb(), V_DEC, "decode");
    case (op)
      6'b100011: begin
        step(rb(), V_ADR, "lw_adr");
        repeat (mw) step(1'b0, V_RD, "lw_rd_wait");
        step(1'b1, V_RD, "lw_rd");
        step(rb(), V_MWB, "lw_wb");
        exp_cnt++;
      end
      6'b101011: begin
        step(rb(), V_ADR, "sw_adr");
        repeat (mw) step(1'b0, V_WR, "sw_wr_wait");
        step(1'b1, V_WR, "sw_wr");
        exp_cnt++;
      end
      6'b000000: begin
        step(rb(), V_EXEC, "r_exec");
        step(rb(), V_AWB, "r_wb");
        exp_cnt++;
      end
      6'b000100: begin
        step(rb(), V_BR, "beq");
        exp_cnt++;
      end
      6'b001000: begin
        step(rb(), V_ADR, "addi_ex");
        step(rb(), V_IWB, "addi_wb");
        exp_cnt++;
      end
      6'b000010: begin
        step(rb(), V_JMP, "jump");
        exp_cnt++;
      end
      default: exp_ill = 1'b1;
    endcase
  endtask
  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset ctl", 32'(obs()), 32'(V_IDLE));
    check("reset count", bus.instr_count, 32'd0);
    check("reset illegal", 32'(bus.illegal_op), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(rb(), V_IDLE, "idle");
    run_instr(6'b100011, 0, 0);
    check("lw retired", bus.instr_count, 32'd1);
    run_instr(6'b000000, 3, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    check("beq+j retired", bus.instr_count, 32'd4);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 1, 0);
    run_instr(6'b101011, 0, 2);
    check("illegal sticky", 32'(bus.illegal_op), 32'd1);
    for (int i = 0; i < 150; i++) begin
      int k;
      k = int'($urandom_range(0, 7));
      op = (k < 6) ? ops[k] : 6'($urandom);
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    bus.opcode = 6'b101011;
    step(1'b1, V_FG, "fetch");
    step(1'b1, V_DEC, "decode");
    step(1'b1, V_ADR, "sw_adr");
    step(1'b0, V_WR, "sw_wr_wait");
    bus.mem_ready = 1'b0;
    #2;
    check("memwr before reset", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset mem_write", 32'(bus.mem_write), 32'd0);
    check("async reset ctl", 32'(obs()), 32'(V_IDLE));
    check("async reset count", bus.instr_count, 32'd0);
    check("async reset illegal", 32'(bus.illegal_op), 32'd0);
    exp_cnt = '0;
    exp_ill = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(rb(), V_IDLE, "idle");
    repeat (16) run_instr(6'b000010, 0, 0);
    check("wrap count4", 32'(bus4.instr_count), 32'd0);
    check("no wrap count32", bus.instr_count, 32'd16);
    step(1'b0, V_FW, "fetch_after_wrap");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
